// File: rtl/operand_fwd_ctrl.sv
// Operand-forwarding control: tracks EX/MEM/WB destinations, drives the ALU A/B
// operand-select buses, and stalls ID for one cycle on a load-use dependency.
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  id_use_imm,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  we;
        logic                  ld;
        logic                  imm;
    } ex_t;

    ex_t                   ex_q, ex_d;
    logic                  mem_vld_q, mem_we_q, mem_ld_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_vld_q, wb_we_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    function automatic logic hit(input logic vld, input logic we,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] r);
        return vld && we && (rd == r) && (r != '0);
    endfunction

    // A load sitting in MEM has no data yet; it is never a 01 source.
    assign mem_hit_a = hit(mem_vld_q & ~mem_ld_q, mem_we_q, mem_rd_q, ex_q.rs1);
    assign mem_hit_b = hit(mem_vld_q & ~mem_ld_q, mem_we_q, mem_rd_q, ex_q.rs2);
    assign wb_hit_a  = hit(wb_vld_q, wb_we_q, wb_rd_q, ex_q.rs1);
    assign wb_hit_b  = hit(wb_vld_q, wb_we_q, wb_rd_q, ex_q.rs2);

    assign stall = id_valid && ex_q.vld && ex_q.we && ex_q.ld && (ex_q.rd != '0) &&
                   ((id_rs1 == ex_q.rd) || ((id_rs2 == ex_q.rd) && !id_use_imm));

    always_comb begin
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (ex_q.vld) begin
            if (mem_hit_a)     fwd_sel_a = 2'b01;
            else if (wb_hit_a) fwd_sel_a = 2'b10;
            if (ex_q.imm)      fwd_sel_b = 2'b11;
            else if (mem_hit_b) fwd_sel_b = 2'b01;
            else if (wb_hit_b)  fwd_sel_b = 2'b10;
        end
    end

    // Flush and stall both turn the EX insert into a bubble.
    always_comb begin
        ex_d = '{vld: id_valid & ~stall & ~flush, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                 we: id_we, ld: id_is_load, imm: id_use_imm};
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_vld_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_ld_q  <= 1'b0;
            mem_rd_q  <= '0;
            wb_vld_q  <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_vld_q <= ex_q.vld;
            mem_we_q  <= ex_q.we;
            mem_ld_q  <= ex_q.ld;
            mem_rd_q  <= ex_q.rd;
            wb_vld_q  <= mem_vld_q;
            wb_we_q   <= mem_we_q;
            wb_rd_q   <= mem_rd_q;
            cnt_q     <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: the driver pushes hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_we, id_is_load, id_use_imm, flush;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       stall, stall8;
    logic [1:0] sel_a, sel_b, sel_a8, sel_b8;
    logic [15:0] cnt;
    logic [7:0]  cnt8;

    always #5 clk = ~clk;

    operand_fwd_ctrl #(.REG_ADDR_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_use_imm(id_use_imm),
        .flush(flush), .stall(stall), .fwd_sel_a(sel_a), .fwd_sel_b(sel_b),
        .stall_count(cnt)
    );

    // Narrow-counter twin so saturation is reachable in a short run.
    operand_fwd_ctrl #(.REG_ADDR_W(3), .CNT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_use_imm(id_use_imm),
        .flush(flush), .stall(stall8), .fwd_sel_a(sel_a8), .fwd_sel_b(sel_b8),
        .stall_count(cnt8)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic        st;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] c;
        logic [7:0]  c8;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled", e.name, e.cyc);
            end else if ({stall, sel_a, sel_b, cnt} !== {e.st, e.a, e.b, e.c} ||
                         {stall8, sel_a8, sel_b8, cnt8} !== {e.st, e.a, e.b, e.c8}) begin
                errors++;
                $display("FAIL %s: got st=%0b a=%0d b=%0d cnt=%0d | st8=%0b a8=%0d b8=%0d cnt8=%0d, want st=%0b a=%0d b=%0d cnt=%0d cnt8=%0d",
                         e.name, stall, sel_a, sel_b, cnt, stall8, sel_a8, sel_b8, cnt8,
                         e.st, e.a, e.b, e.c, e.c8);
            end
        end
    end

    task automatic issue(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic we, input logic ld,
                         input logic imm, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_we = we; id_is_load = ld; id_use_imm = imm; flush = fl;
    endtask

    task automatic nop();
        issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic st, input logic [1:0] a,
                       input logic [1:0] b, input int c);
        exp_t e;
        e.cyc = cyc; e.name = name; e.st = st; e.a = a; e.b = b;
        e.c  = 16'(c);
        e.c8 = (c > 255) ? 8'd255 : 8'(c);
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_we = 0; id_is_load = 0; id_use_imm = 0; flush = 0;

        nop(); chk("in_reset", 0, 0, 0, 0);
        nop(); rst_n = 1'b1; chk("rst_release", 0, 0, 0, 0);
        repeat (3) begin nop(); chk("bubble_stream", 0, 0, 0, 0); end

        // ADD r1 ; ADD r2=r1+r3 back-to-back, then with one NOP gap
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("t0", 0, 0, 0, 0);
        issue(1, 1, 3, 2, 1, 0, 0, 0); chk("t1", 0, 0, 0, 0);
        nop();                         chk("b2b_mem_fwd", 0, 2'b01, 2'b00, 0);
        nop();                         chk("t3", 0, 0, 0, 0);
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("t4", 0, 0, 0, 0);
        nop();                         chk("t5", 0, 0, 0, 0);
        issue(1, 1, 3, 2, 1, 0, 0, 0); chk("t6", 0, 0, 0, 0);
        nop();                         chk("gap_wb_fwd", 0, 2'b10, 2'b00, 0);

        // r1 written in both MEM and WB: younger MEM wins; immediate overrides B
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("u0", 0, 0, 0, 0);
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("u1", 0, 0, 0, 0);
        issue(1, 1, 1, 3, 1, 0, 0, 0); chk("u2", 0, 0, 0, 0);
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("mem_over_wb", 0, 2'b01, 2'b01, 0);
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("u4", 0, 0, 0, 0);
        issue(1, 1, 1, 3, 1, 0, 1, 0); chk("u5", 0, 0, 0, 0);
        nop();                         chk("imm_override", 0, 2'b01, 2'b11, 0);
        nop();                         chk("u7", 0, 0, 0, 0);

        // LOAD r4 ; ADD r5=r4+r4
        issue(1, 0, 0, 4, 1, 1, 0, 0); chk("v0", 0, 0, 0, 0);
        issue(1, 4, 4, 5, 1, 0, 0, 0); chk("load_use_stall", 1, 0, 0, 0);
        issue(1, 4, 4, 5, 1, 0, 0, 0); chk("load_use_bubble", 0, 0, 0, 1);
        nop();                         chk("load_wb_fwd", 0, 2'b10, 2'b10, 1);
        nop();                         chk("v4", 0, 0, 0, 1);

        // r0 never forwards and a LOAD r0 never stalls
        issue(1, 2, 3, 0, 1, 0, 0, 0); chk("w0", 0, 0, 0, 1);
        issue(1, 0, 0, 6, 1, 0, 0, 0); chk("w1", 0, 0, 0, 1);
        issue(1, 0, 0, 0, 1, 1, 0, 0); chk("r0_no_fwd", 0, 0, 0, 1);
        issue(1, 0, 0, 6, 1, 0, 0, 0); chk("r0_load_no_stall", 0, 0, 0, 1);
        nop();                         chk("w4", 0, 0, 0, 1);

        // Load-use stall coinciding with flush, then flush killing a producer
        issue(1, 0, 0, 4, 1, 1, 0, 0); chk("x0", 0, 0, 0, 1);
        issue(1, 4, 0, 5, 1, 0, 0, 1); chk("stall_with_flush", 1, 0, 0, 1);
        issue(1, 4, 0, 5, 1, 0, 0, 0); chk("flush_bubble_cnt", 0, 0, 0, 2);
        nop();                         chk("after_flush_fwd", 0, 2'b10, 2'b00, 2);
        issue(1, 0, 0, 1, 1, 0, 0, 1); chk("x4", 0, 0, 0, 2);
        issue(1, 1, 1, 2, 1, 0, 0, 0); chk("x5", 0, 0, 0, 2);
        nop();                         chk("flush_kills_producer", 0, 0, 0, 2);

        // Async reset mid-stream
        issue(1, 0, 0, 1, 1, 0, 0, 0); chk("y0", 0, 0, 0, 2);
        issue(1, 1, 1, 2, 1, 0, 0, 0); chk("y1", 0, 0, 0, 2);
        issue(1, 1, 1, 3, 1, 0, 0, 0); chk("pre_reset", 0, 2'b01, 2'b01, 2);
        issue(1, 2, 2, 4, 1, 0, 0, 0); rst_n = 1'b0; chk("async_reset", 0, 0, 0, 0);
        nop();                         chk("reset_held", 0, 0, 0, 0);
        nop(); rst_n = 1'b1;           chk("reset_rerelease", 0, 0, 0, 0);

        // LOAD r4 that reads r4, held in ID: stalls on every even cycle
        issue(1, 4, 0, 4, 1, 1, 0, 0);
        for (int i = 2; i <= 518; i++) begin
            @(posedge clk);
            #1;
            if (i == 512) chk("sat_mid", 1, 2'b10, 2'b00, 255);
        end
        nop(); chk("sat_end", 0, 0, 0, 259);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors += q.size();
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
